debug_trace_buffer: RTL
=======================

Name: debug_trace_buffer

Overview:
- Captures the per-instruction debug stream (PC, instruction, cache-miss, branch-taken and stall flags, cycle count) into a circular on-chip buffer.
- Uses an arm/trigger/post-trigger scheme to freeze the buffer, then drains the captured entries oldest-first over a valid/ready read port.
- Sits beside the core's debug tap and feeds the external debug host, which reads the trace back after a trigger.

Parameters:
- DEPTH, 16, number of trace entries; power of two, at least 2.
- POST_TRIG, 4, entries captured after (excluding) the trigger entry; range 0..DEPTH-1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- arm  in  1  single-cycle pulse; clears the buffer and starts capture
- trig_en  in  1  enables PC-match trigger
- trig_pc  in  64  trigger PC value
- pc  in  64  retiring PC
- instr  in  32  retiring instruction
- valid  in  1  debug event qualifier
- cache_miss  in  1  event flag
- branch_taken  in  1  event flag
- stall  in  1  event flag
- cycle  in  64  cycle counter value
- rd_valid  out  1  read entry available
- rd_ready  in  1  host accepts entry
- rd_pc  out  64  entry PC
- rd_instr  out  32  entry instruction
- rd_flags  out  3  {cache_miss, branch_taken, stall}
- rd_cycle  out  64  entry cycle stamp (see Optional Feature)
- rd_last  out  1  current entry is the final one
- state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3
- count  out  $clog2(DEPTH)+1  entries held
- overflow  out  1  at least one entry was overwritten since arm

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; count=0; write and post counters=0; overflow=0.
  - rd_valid=0, rd_last=0, all rd_* data=0.
  - Takes effect immediately, including mid-capture and mid-readout.
- IDLE: no capture. arm -> ARMED next cycle; wr_ptr, count and overflow are cleared.
- ARMED, on each cycle with valid=1:
  - Write {pc, instr, flags[, cycle]} at wr_ptr; wr_ptr increments mod DEPTH.
  - If count<DEPTH, count++. Otherwise count holds, overflow<=1, and the oldest entry is lost.
  - Flags are recorded as sampled; stall does not suppress capture.
- Trigger: in ARMED, valid=1 && trig_en=1 && pc==trig_pc.
  - The triggering entry is written.
  - POST_TRIG==0 -> DONE; otherwise post_cnt<=POST_TRIG and -> POST.
- POST:
  - Writes continue as in ARMED.
  - post_cnt decrements only on valid cycles.
  - The write that takes post_cnt from 1 to 0 -> DONE.
  - Further PC matches are ignored.
- DONE: capture disabled.
  - rd_valid = (count!=0), registered.
  - Read entry index = (wr_ptr - count) mod DEPTH, i.e. oldest-first.
  - rd_last = (count==1).
  - Handshake fires on rd_valid && rd_ready: count-- and the next entry is presented the following cycle.
  - Data is stable while rd_valid && !rd_ready.
  - When count reaches 0: rd_valid<=0 -> IDLE.
  - DONE with count==0 on entry (trigger with empty buffer is impossible, so this does not occur).
- arm in any state other than IDLE restarts immediately: -> ARMED, count=0, overflow=0, rd_valid=0; any readout in progress is aborted.
- arm and valid in the same cycle: arm wins; that event is not captured.
- rd_ready outside DONE is ignored.
- Pointer arithmetic is modulo DEPTH; count never exceeds DEPTH.

Optional Feature:
- Macro: DBG_TRACE_CYCLE_EN.
- Defined: each entry stores cycle[63:0]; rd_cycle presents the stamp of the current entry.
- Undefined: no cycle storage is built; cycle is ignored and rd_cycle is tied to 0.
- State and handshake behaviour are identical in both builds.

Test Plan (DEPTH=4, POST_TRIG=2):
- Overflow wrap: arm; trig_en=1, trig_pc=0x108; events pc 0x100, 0x104, 0x108 (trigger), 0x10C, 0x110 -> state=DONE, count=4, overflow=1. Reads return 0x104, 0x108, 0x10C, 0x110, with rd_last only on 0x110, then state=IDLE.
- Valid gaps in POST: trigger at 0x200, then valid=0 for 3 cycles, then events 0x204, 0x208 -> stays POST through the gaps, DONE after 0x208. count=3, overflow=0, reads 0x200, 0x204, 0x208.
- Backpressure: in DONE hold rd_ready=0 for 3 cycles -> rd_valid=1 and rd_pc/rd_instr/rd_flags unchanged; count unchanged until rd_ready=1.
- Re-arm mid-readout: after 1 of 3 reads, pulse arm -> next cycle state=ARMED, count=0, rd_valid=0, overflow=0.
- Async reset in POST: assert rst between clock edges -> state=0, count=0, rd_valid=0 immediately; after release, valid events are not captured until arm.
- Cycle stamp: with DBG_TRACE_CYCLE_EN defined, capture at cycle=0x3E8 -> rd_cycle=0x3E8 on readout; with it undefined, rd_cycle=0.

Source files
------------

// File: rtl/debug_trace_buffer.sv
// debug_trace_buffer: circular capture buffer for the per-instruction debug stream.
// An arm pulse clears the buffer and starts capture. A PC-match trigger plus
// POST_TRIG further events freeze it. The frozen entries then drain oldest-first
// over a valid/ready read port.
//
// Optional build macro: DBG_TRACE_CYCLE_EN stores a 64-bit cycle stamp per entry.
// Without it, no cycle storage is built and rd_cycle is tied to 0.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   arm                         clear buffer and start capture (any state)
//   trig_en, trig_pc            PC-match trigger enable and value
//   pc, instr, valid            retiring instruction and its qualifier
//   cache_miss, branch_taken,
//   stall                       event flags
//   cycle                       cycle counter value
//   rd_valid, rd_ready          read handshake
//   rd_pc, rd_instr, rd_flags,
//   rd_cycle, rd_last           current read entry
//   state, count, overflow      status
module debug_trace_buffer #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned POST_TRIG = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     trig_en,
    input  logic [63:0]              trig_pc,
    input  logic [63:0]              pc,
    input  logic [31:0]              instr,
    input  logic                     valid,
    input  logic                     cache_miss,
    input  logic                     branch_taken,
    input  logic                     stall,
    input  logic [63:0]              cycle,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [63:0]              rd_pc,
    output logic [31:0]              rd_instr,
    output logic [2:0]               rd_flags,
    output logic [63:0]              rd_cycle,
    output logic                     rd_last,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          r_state, w_state_nx;
    logic [AW-1:0]   r_wr_ptr, w_wr_ptr_nx;
    logic [CW-1:0]   r_count, w_count_nx;
    logic [AW-1:0]   r_post_cnt, w_post_nx;
    logic            r_overflow, w_ovf_nx;
    logic            w_wr_en;
    logic            w_hit;
    logic            w_fire;
    logic            w_rd_load;
    logic            w_rd_valid_nx;
    logic            w_rd_last_nx;
    logic [AW-1:0]   w_rd_idx;

    logic            r_rd_valid;
    logic [63:0]     r_rd_pc;
    logic [31:0]     r_rd_instr;
    logic [2:0]      r_rd_flags;
    logic            r_rd_last;

    logic [63:0]     r_mem_pc    [DEPTH];
    logic [31:0]     r_mem_instr [DEPTH];
    logic [2:0]      r_mem_flags [DEPTH];

    assign w_hit  = valid && trig_en && (pc == trig_pc);
    assign w_fire = r_rd_valid && rd_ready;

    // State register and status counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_post_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_wr_ptr   <= w_wr_ptr_nx;
            r_count    <= w_count_nx;
            r_post_cnt <= w_post_nx;
            r_overflow <= w_ovf_nx;
        end
    end

    // Next-state, capture and readout control
    always_comb begin
        w_state_nx    = r_state;
        w_wr_ptr_nx   = r_wr_ptr;
        w_count_nx    = r_count;
        w_post_nx     = r_post_cnt;
        w_ovf_nx      = r_overflow;
        w_wr_en       = 1'b0;
        w_rd_load     = 1'b0;
        w_rd_valid_nx = 1'b0;
        w_rd_last_nx  = 1'b0;

        if (arm) begin
            // arm wins over a same-cycle event and aborts any readout
            w_state_nx  = ST_ARMED;
            w_wr_ptr_nx = '0;
            w_count_nx  = '0;
            w_post_nx   = '0;
            w_ovf_nx    = 1'b0;
        end else begin
            case (r_state)
                ST_ARMED, ST_POST: begin
                    if (valid) begin
                        w_wr_en     = 1'b1;
                        w_wr_ptr_nx = r_wr_ptr + AW'(1);
                        if (r_count == CW'(DEPTH)) begin
                            w_ovf_nx = 1'b1;
                        end else begin
                            w_count_nx = r_count + CW'(1);
                        end
                        if (r_state == ST_ARMED) begin
                            if (w_hit) begin
                                if (POST_TRIG == 0) begin
                                    w_state_nx = ST_DONE;
                                end else begin
                                    w_post_nx  = AW'(POST_TRIG);
                                    w_state_nx = ST_POST;
                                end
                            end
                        end else begin
                            w_post_nx = r_post_cnt - AW'(1);
                            if (r_post_cnt == AW'(1)) begin
                                w_state_nx = ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (w_fire) begin
                        w_count_nx = r_count - CW'(1);
                    end
                    w_rd_valid_nx = (w_count_nx != '0);
                    w_rd_last_nx  = (w_count_nx == CW'(1));
                    w_rd_load     = w_rd_valid_nx;
                    if (w_count_nx == '0) begin
                        w_state_nx = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Oldest entry after this cycle's handshake; a full buffer wraps to wr_ptr
    assign w_rd_idx = r_wr_ptr - w_count_nx[AW-1:0];

    // Entry storage
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_pc[r_wr_ptr]    <= pc;
            r_mem_instr[r_wr_ptr] <= instr;
            r_mem_flags[r_wr_ptr] <= {cache_miss, branch_taken, stall};
        end
    end

    // Registered read port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_pc    <= '0;
            r_rd_instr <= '0;
            r_rd_flags <= '0;
        end else begin
            r_rd_valid <= w_rd_valid_nx;
            r_rd_last  <= w_rd_last_nx;
            if (w_rd_load) begin
                r_rd_pc    <= r_mem_pc[w_rd_idx];
                r_rd_instr <= r_mem_instr[w_rd_idx];
                r_rd_flags <= r_mem_flags[w_rd_idx];
            end
        end
    end

`ifdef DBG_TRACE_CYCLE_EN
    logic [63:0] r_mem_cycle [DEPTH];
    logic [63:0] r_rd_cycle;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_cycle[r_wr_ptr] <= cycle;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_cycle <= '0;
        end else if (w_rd_load) begin
            r_rd_cycle <= r_mem_cycle[w_rd_idx];
        end
    end

    assign rd_cycle = r_rd_cycle;
`else
    logic w_unused_cycle;
    assign w_unused_cycle = ^cycle;
    assign rd_cycle       = '0;
`endif

    assign rd_valid = r_rd_valid;
    assign rd_pc    = r_rd_pc;
    assign rd_instr = r_rd_instr;
    assign rd_flags = r_rd_flags;
    assign rd_last  = r_rd_last;
    assign state    = r_state;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule
